// File: rtl/pattern_serializer.sv
// Serialises a WIDTH-bit pattern MSB first on registered x, optionally repeated with GAP idle-zero cycles between frames.
// First bit appears on the accept edge. No backpressure: start is ignored while busy and on the edge that ends the last bit.
module pattern_serializer #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNTW-1:0]  reps,
    output logic             x,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] pat, pat_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [CNTW-1:0]  frames, frames_n;
    logic [GW-1:0]    gapcnt, gapcnt_n;
    logic             x_n, busy_n, done_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            shreg  <= '0;
            pat    <= '0;
            bitcnt <= '0;
            frames <= '0;
            gapcnt <= '0;
            x      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            pat    <= pat_n;
            bitcnt <= bitcnt_n;
            frames <= frames_n;
            gapcnt <= gapcnt_n;
            x      <= x_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // shreg holds the bits still to be sent, next one in the MSB position
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        pat_n    = pat;
        bitcnt_n = bitcnt;
        frames_n = frames;
        gapcnt_n = gapcnt;
        x_n      = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    pat_n    = data;
                    shreg_n  = {data[WIDTH-2:0], 1'b0};
                    frames_n = (reps == '0) ? CNTW'(1) : reps;
                    x_n      = data[WIDTH-1];
                    busy_n   = 1'b1;
                    bitcnt_n = BW'(1);
                    state_n  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bitcnt != BW'(WIDTH)) begin
                    x_n      = shreg[WIDTH-1];
                    shreg_n  = {shreg[WIDTH-2:0], 1'b0};
                    bitcnt_n = bitcnt + BW'(1);
                end else if (frames == CNTW'(1)) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (GAP > 0) begin
                    frames_n = frames - CNTW'(1);
                    gapcnt_n = GW'(1);
                    state_n  = S_GAP;
                end else begin
                    frames_n = frames - CNTW'(1);
                    x_n      = pat[WIDTH-1];
                    shreg_n  = {pat[WIDTH-2:0], 1'b0};
                    bitcnt_n = BW'(1);
                end
            end
            S_GAP: begin
                if (gapcnt == GW'(GAP)) begin
                    x_n      = pat[WIDTH-1];
                    shreg_n  = {pat[WIDTH-2:0], 1'b0};
                    bitcnt_n = BW'(1);
                    state_n  = S_SHIFT;
                end else begin
                    gapcnt_n = gapcnt + GW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: two instances (GAP=2 and GAP=0) driven by shared stimulus,
// checked every cycle against a timing-formula model of the expected x/busy/done waveform.
module tb_pattern_serializer;
    localparam int WIDTH = 4;
    localparam int CNTW  = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [CNTW-1:0]  reps;
    logic [1:0]       x_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model: per instance, the accept edge, pattern and frame count of the current transfer
    bit               m_act [2];
    int               m_t0  [2];
    logic [WIDTH-1:0] m_pat [2];
    int               m_n   [2];

    pattern_serializer #(.WIDTH(WIDTH), .GAP(GAP_A), .CNTW(CNTW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .data(data), .reps(reps),
        .x(x_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    pattern_serializer #(.WIDTH(WIDTH), .GAP(GAP_B), .CNTW(CNTW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .data(data), .reps(reps),
        .x(x_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic int flen(input int n, input int g);
        return n * WIDTH + (n - 1) * g;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_act[i] = 1'b0;
            end else if (start && (!m_act[i] || (cyc - m_t0[i]) >= flen(m_n[i], gap_of(i)) + 1)) begin
                m_act[i] = 1'b1;
                m_t0[i]  = cyc;
                m_pat[i] = data;
                m_n[i]   = (reps == '0) ? 1 : int'(reps);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic ex, eb, ed;
            int   e, len, ph;
            ex = 1'b0; eb = 1'b0; ed = 1'b0;
            if (m_act[i]) begin
                e   = cyc - m_t0[i];
                len = flen(m_n[i], gap_of(i));
                if (e < len) begin
                    eb = 1'b1;
                    ph = e % (WIDTH + gap_of(i));
                    if (ph < WIDTH) ex = m_pat[i][WIDTH-1-ph];
                end else if (e == len) begin
                    ed = 1'b1;
                end
            end
            check($sformatf("x%0d", i), 32'(x_v[i]), 32'(ex));
            check($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(eb));
            check($sformatf("done%0d", i), 32'(done_v[i]), 32'(ed));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic transfer(input string tag, input logic [WIDTH-1:0] d, input logic [CNTW-1:0] r);
        int cnt0, cnt1, n, k;
        n = (r == '0) ? 1 : int'(r);
        start = 1'b1; data = d; reps = r;
        tick();
        start = 1'b0; data = WIDTH'($urandom); reps = CNTW'($urandom);
        cnt0 = 0; cnt1 = 0; k = 0;
        while (busy_v != 2'b00 && k < 300) begin
            cnt0 += int'(busy_v[0]);
            cnt1 += int'(busy_v[1]);
            tick();
            k++;
        end
        check({tag, "_timeout"}, 32'(k < 300), 32'd1);
        check({tag, "_busylen_gap2"}, 32'(cnt0), 32'(flen(n, GAP_A)));
        check({tag, "_busylen_gap0"}, 32'(cnt1), 32'(flen(n, GAP_B)));
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; data = '0; reps = '0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_t0[i] = 0; m_pat[i] = '0; m_n[i] = 1;
        end
        #3;
        check_all();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // single frame, reps=0 means one frame
        transfer("single", 4'b1000, 4'd0);
        // three frames with gap (back-to-back on the GAP=0 instance)
        transfer("rep3", 4'b1011, 4'd3);
        transfer("rep2", 4'b0110, 4'd2);
        transfer("rep15", 4'b1101, 4'd15);

        // reset mid-frame: outputs drop immediately, no done after release
        start = 1'b1; data = 4'b1000; reps = 4'd1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        m_act[0] = 1'b0; m_act[1] = 1'b0;
        #1;
        check_all();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        transfer("after_rst", 4'b1000, 4'd1);

        // start held through a transfer: ignored while busy and at the final-bit edge
        start = 1'b1; data = 4'b1000; reps = 4'd1;
        tick();
        data = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        tick();
        check("ign_end_busy", 32'(busy_v[0]), 32'd0);
        check("ign_end_done", 32'(done_v[0]), 32'd1);
        tick();
        check("reaccept_busy", 32'(busy_v[0]), 32'd1);
        check("reaccept_done", 32'(done_v[0]), 32'd0);
        check("reaccept_x", 32'(x_v[0]), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 3) == 0);
            data  = WIDTH'($urandom);
            reps  = ($urandom_range(0, 9) == 0) ? CNTW'(15) : CNTW'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                m_act[0] = 1'b0; m_act[1] = 1'b0;
                #1;
                check_all();
                tick();
                reset = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 100; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
